// File: rtl/mips_mdu_pkg.sv
// mdu_pkg: shared types for the MIPS multiply/divide unit.
// Op codes seen on the EX-stage bus and the MDU sequencer states.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIXUP
  } mdu_state_t;

endpackage

// File: rtl/mips_mdu_if.sv
// mips_mdu_if: EX-stage <-> MDU bundle.
// master drives start/op/src1/src2/flush; slave returns busy/done/hi/lo.
interface mips_mdu_if
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
);

  logic             start;
  mdu_op_t          op;
  logic [WIDTH-1:0] src1;
  logic [WIDTH-1:0] src2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, src1, src2, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, src1, src2, flush,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mips_mdu_divstep.sv
// mdu_divstep: one combinational restoring-division step.
// In: rem, quo (dividend bits shift out MSB first), dvs. Out: rem_n, quo_n.
module mdu_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH:0]   sh;
  logic [WIDTH-1:0] diff;
  logic             ge;

  always_comb begin
    sh    = {rem, quo[WIDTH-1]};
    ge    = (sh >= {1'b0, dvs});
    // When ge holds the true difference is below dvs, so it fits
    // in WIDTH bits; with dvs=0 it is just the shifted remainder.
    diff  = sh[WIDTH-1:0] - dvs;
    rem_n = ge ? diff : sh[WIDTH-1:0];
    quo_n = {quo[WIDTH-2:0], ge};
  end

endmodule

// File: rtl/mips_mdu.sv
// mips_mdu: iterative MULT/MULTU/DIV/DIVU plus MTHI/MTLO, owns HI/LO.
// Ports: clk, resetn (async low), bus (mips_mdu_if.slave).
module mips_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  mips_mdu_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mdu_state_t         state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   dvs;
  logic               is_div;
  logic               neg_q;
  logic               neg_r;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic               take;
  logic               op_mul;
  logic               op_dv;
  logic               op_md;
  logic               op_hi;
  logic               op_lo;
  logic               op_sgn;
  logic               s1n;
  logic               s2n;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     msum;
  logic [2*WIDTH-1:0] mul_n;
  logic [WIDTH-1:0]   rem_n;
  logic [WIDTH-1:0]   quo_n;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   q_fix;
  logic [WIDTH-1:0]   r_fix;

  mdu_divstep #(
    .WIDTH (WIDTH)
  ) u_divstep (
    .rem   (acc[2*WIDTH-1:WIDTH]),
    .quo   (acc[WIDTH-1:0]),
    .dvs   (dvs),
    .rem_n (rem_n),
    .quo_n (quo_n)
  );

  always_comb begin
    take   = bus.start & ~bus.flush & (state == IDLE);
    op_mul = (bus.op == MDU_MULT) | (bus.op == MDU_MULTU);
    op_dv  = (bus.op == MDU_DIV)  | (bus.op == MDU_DIVU);
    op_md  = op_mul | op_dv;
    op_hi  = (bus.op == MDU_MTHI);
    op_lo  = (bus.op == MDU_MTLO);
    op_sgn = (bus.op == MDU_MULT) | (bus.op == MDU_DIV);
    s1n    = op_sgn & bus.src1[WIDTH-1];
    s2n    = op_sgn & bus.src2[WIDTH-1];
    a_mag  = s1n ? -bus.src1 : bus.src1;
    b_mag  = s2n ? -bus.src2 : bus.src2;

    // Shift-add: acc = {partial, multiplier}; acc[0] is the live bit.
    msum   = {1'b0, acc[2*WIDTH-1:WIDTH]}
           + (acc[0] ? {1'b0, dvs} : '0);
    mul_n  = {msum, acc[WIDTH-1:1]};

    prod   = neg_q ? -acc : acc;
    q_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    r_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH]
                   : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      dvs    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            unique case (1'b1)
              op_md: begin
                state  <= CALC;
                cnt    <= '0;
                is_div <= op_dv;
                if (op_dv) begin
                  acc   <= {{WIDTH{1'b0}}, a_mag};
                  dvs   <= b_mag;
                  // Divide by zero keeps the all-ones quotient
                  // unsigned; the remainder sign restores src1.
                  neg_q <= (s1n ^ s2n) & (bus.src2 != '0);
                  neg_r <= s1n;
                end else begin
                  acc   <= {{WIDTH{1'b0}}, b_mag};
                  dvs   <= a_mag;
                  neg_q <= s1n ^ s2n;
                  neg_r <= 1'b0;
                end
              end
              op_hi: hi_q <= bus.src1;
              op_lo: lo_q <= bus.src1;
              default: ;
            endcase
          end
        end
        CALC: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            acc <= is_div ? {rem_n, quo_n} : mul_n;
            cnt <= cnt + CW'(1);
            if (cnt == LAST) state <= FIXUP;
          end
        end
        FIXUP: begin
          state <= IDLE;
          if (!bus.flush) begin
            done_q <= 1'b1;
            if (is_div) begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end else begin
              {hi_q, lo_q} <= prod;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
// tb_mips_mdu: randomized + directed bench for mips_mdu.
// Reference results come from plain 64-bit / int arithmetic.
module tb_mips_mdu;
  import mdu_pkg::*;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mips_mdu_if #(.WIDTH(32)) bus ();

  mips_mdu #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] mhi = '0;
  logic [31:0] mlo = '0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] ref_md(input mdu_op_t o,
                                         input logic [31:0] a,
                                         input logic [31:0] b);
    logic [63:0] r;
    longint sa, sb;
    int ia, ib;
    logic [31:0] q, m;
    r  = '0;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (o)
      MDU_MULTU: r = {32'd0, a} * {32'd0, b};
      MDU_MULT:  r = 64'(sa * sb);
      MDU_DIVU: begin
        if (b == 0) r = {a, 32'hFFFF_FFFF};
        else        r = {a % b, a / b};
      end
      MDU_DIV: begin
        if (b == 0) begin
          r = {a, 32'hFFFF_FFFF};
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          r = {32'd0, 32'h8000_0000};
        end else begin
          q = ia / ib;
          m = ia % ib;
          r = {m, q};
        end
      end
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick;
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Launch one mult/div; optionally keep a bogus start asserted for
  // `hold` cycles while busy. Returns in the done cycle.
  task automatic run_md(input mdu_op_t o, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [63:0] r;
    int cyc, nb;
    r = ref_md(o, a, b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.src1  = a;
    bus.src2  = b;
    tick();
    bus.op    = MDU_MULTU;
    bus.src1  = 32'h0000_0003;
    bus.src2  = 32'h0000_0009;
    bus.start = (hold > 0);
    chk("done_clr", 64'(bus.done), 64'd0);
    cyc = 1;
    nb  = 0;
    while (!bus.done && cyc < 40) begin
      if (bus.busy) nb++;
      if (cyc >= hold) bus.start = 1'b0;
      tick();
      cyc++;
    end
    bus.start = 1'b0;
    chk("latency", 64'(cyc), 64'd34);
    chk("busy_cyc", 64'(nb), 64'd33);
    chk("busy_at_done", 64'(bus.busy), 64'd0);
    mhi = r[63:32];
    mlo = r[31:0];
    chk($sformatf("hi op%0d %h %h", o, a, b), 64'(bus.hi), 64'(mhi));
    chk($sformatf("lo op%0d %h %h", o, a, b), 64'(bus.lo), 64'(mlo));
  endtask

  // Start an op then abort it at cycle T0+at by flush or by reset.
  task automatic abort_md(input mdu_op_t o, input logic [31:0] a,
                          input logic [31:0] b, input int at,
                          input bit use_rst);
    int seen;
    bus.start = 1'b1;
    bus.op    = o;
    bus.src1  = a;
    bus.src2  = b;
    tick();
    bus.start = 1'b0;
    repeat (at - 1) tick();
    if (use_rst) begin
      resetn = 1'b0;
      #1;
      mhi = '0;
      mlo = '0;
      chk("rst_busy", 64'(bus.busy), 64'd0);
      chk("rst_done", 64'(bus.done), 64'd0);
      chk("rst_hi", 64'(bus.hi), 64'd0);
      chk("rst_lo", 64'(bus.lo), 64'd0);
      resetn = 1'b1;
    end else begin
      chk("pre_flush_busy", 64'(bus.busy), 64'd1);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      chk($sformatf("flush%0d_busy", at), 64'(bus.busy), 64'd0);
      chk($sformatf("flush%0d_done", at), 64'(bus.done), 64'd0);
      chk($sformatf("flush%0d_hi", at), 64'(bus.hi), 64'(mhi));
      chk($sformatf("flush%0d_lo", at), 64'(bus.lo), 64'(mlo));
    end
    seen = 0;
    repeat (40) begin
      tick();
      if (bus.done || bus.busy) seen++;
    end
    chk("abort_quiet", 64'(seen), 64'd0);
    chk("abort_hi", 64'(bus.hi), 64'(mhi));
    chk("abort_lo", 64'(bus.lo), 64'(mlo));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = MDU_MULT;
    bus.src1  = '0;
    bus.src2  = '0;
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hi", 64'(bus.hi), 64'd0);
    chk("reset_lo", 64'(bus.lo), 64'd0);
    resetn = 1'b1;
    tick();

    run_md(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_md(MDU_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 0);
    run_md(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_md(MDU_DIVU,  32'hFFFF_FFF9, 32'h0000_0002, 0);
    run_md(MDU_DIVU,  32'h0000_0064, 32'h0000_0000, 0);
    run_md(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_md(MDU_DIV,   32'hFFFF_FFF9, 32'h0000_0000, 0);

    tick();
    bus.start = 1'b1;
    bus.op    = MDU_MTHI;
    bus.src1  = 32'h1234_5678;
    tick();
    mhi = 32'h1234_5678;
    chk("mthi_hi", 64'(bus.hi), 64'(mhi));
    chk("mthi_lo", 64'(bus.lo), 64'(mlo));
    chk("mthi_busy", 64'(bus.busy), 64'd0);
    bus.op   = MDU_MTLO;
    bus.src1 = 32'hCAFE_F00D;
    tick();
    mlo = 32'hCAFE_F00D;
    chk("mtlo_lo", 64'(bus.lo), 64'(mlo));
    chk("mtlo_hi", 64'(bus.hi), 64'(mhi));
    chk("mtlo_busy", 64'(bus.busy), 64'd0);
    bus.op   = mdu_op_t'(3'b110);
    bus.src1 = 32'h5555_AAAA;
    tick();
    bus.start = 1'b0;
    chk("badop_busy", 64'(bus.busy), 64'd0);
    chk("badop_done", 64'(bus.done), 64'd0);
    chk("badop_hi", 64'(bus.hi), 64'(mhi));
    chk("badop_lo", 64'(bus.lo), 64'(mlo));

    bus.start = 1'b1;
    bus.flush = 1'b1;
    bus.op    = MDU_MTHI;
    bus.src1  = 32'hDEAD_BEEF;
    tick();
    bus.op    = MDU_MULT;
    tick();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("flush_start_hi", 64'(bus.hi), 64'(mhi));
    chk("flush_start_busy", 64'(bus.busy), 64'd0);

    run_md(MDU_MULT, 32'h0000_1234, 32'hFFFF_0001, 5);

    abort_md(MDU_MULTU, 32'd5, 32'd6, 10, 1'b0);
    abort_md(MDU_MULTU, 32'd5, 32'd6, 33, 1'b0);
    abort_md(MDU_MULTU, 32'd5, 32'd6, 20, 1'b1);

    run_md(MDU_MULTU, 32'd5, 32'd6, 0);
    for (int i = 0; i < 30; i++) begin
      run_md(mdu_op_t'($urandom_range(0, 3)), pick(), pick(), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_mdu.md
Name: mips_mdu

Overview:
Iterative multiply/divide unit that owns the MIPS32 HI/LO register pair. It sits beside the single-cycle ALU in EX and consumes the same src1/src2 operands. It executes MULT/MULTU/DIV/DIVU over multiple cycles using a start/busy/done handshake, and performs MTHI/MTLO in a single cycle. The pipeline stalls on MFHI/MFLO or a new MDU op while busy=1.

Parameters:
WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
clk  input  1  system clock, rising edge
resetn  input  1  asynchronous active-low reset
start  input  1  request; accepted on an edge where start=1, busy=0, flush=0
op  input  3  operation code (mdu_op_t), sampled at accept
src1  input  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO data)
src2  input  WIDTH  rt operand (multiplier / divisor)
flush  input  1  synchronous abort from exception/branch-flush logic
busy  output  1  multi-cycle operation in progress
done  output  1  one-cycle pulse: HI/LO just updated by a mult/div
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (resetn=0, asynchronous): state=IDLE; busy=0, done=0, hi=0, lo=0; counter and datapath registers cleared. Reset mid-operation abandons it with no done pulse.
- States: IDLE -> CALC (WIDTH cycles) -> FIXUP (1 cycle) -> IDLE.
- Accept at edge T0 with MULT/MULTU/DIV/DIVU: latch operand magnitudes (signed ops: absolute value; unsigned: raw) and result-sign flags; counter=0; go to CALC.
- CALC: one bit per cycle. Multiply uses shift-add into a 2*WIDTH accumulator. Divide uses restoring shift-subtract producing quotient and remainder. Counter increments each cycle; at counter=WIDTH-1, go to FIXUP.
- FIXUP edge applies signs and writes HI/LO, then goes to IDLE; done=1 for exactly the following cycle.
  - Multiply: {hi,lo} = product, negated (two's complement, 64-bit) if the operand signs differ.
  - Divide: lo=quotient, hi=remainder. The quotient is negated if the signs differ. The remainder takes the sign of the dividend (truncating division).
- Latency: busy=1 in cycles T0+1 .. T0+WIDTH+1 (33 cycles). done=1 and new hi/lo are visible in cycle T0+WIDTH+2. A new start is accepted in that same cycle (back-to-back).
- MTHI / MTLO: on the accept edge hi (or lo) <= src1. No busy, no done. The other register is unchanged.
- Other op codes: accepted and ignored; no state change.
- start while busy=1: ignored; the request is not queued. The pipeline holds it.
- Divide by zero (signed or unsigned): hi=src1 as originally presented, lo=all ones. Still takes the full latency and pulses done.
- Signed 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. This is the natural result of the datapath; no trap.
- flush=1: in CALC/FIXUP, go to IDLE at the next edge. busy=0 the next cycle, hi/lo unchanged, no done. flush with start in IDLE: start is not accepted. flush on the FIXUP edge wins, so the HI/LO write is suppressed.
- hi/lo hold their values at all times except on the write edges defined above.

Decomposition:
- Package mdu_pkg holds:
  - typedef enum logic [2:0] mdu_op_t: MDU_MULT=3'b000, MDU_MULTU=3'b001, MDU_DIV=3'b010, MDU_DIVU=3'b011, MDU_MTHI=3'b100, MDU_MTLO=3'b101.
  - The state enum mdu_state_t: IDLE, CALC, FIXUP.
- One sub-module is natural: mdu_divstep, a combinational single restoring-division step taking {rem, quo, divisor} and returning the next {rem, quo}.
- Shift-add multiply stays inline.

Test Plan:
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> busy for 33 cycles; done in cycle T0+34; hi=0xFFFFFFFE, lo=0x00000001.
- MULT 0xFFFFFFFD(-3) x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV 0xFFFFFFF9(-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> lo=0x7FFFFFFC, hi=0x00000001.
- DIVU 100 / 0 -> hi=0x00000064, lo=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MTHI 0x12345678 then MTLO 0xCAFEF00D on consecutive cycles -> each visible the next cycle, busy never asserted. Then start MULT while busy with a second start -> the second start is ignored.
- MULTU 5x6 with flush in cycle T0+10 -> busy=0 in cycle T0+11, no done, hi/lo keep prior values. Repeat with resetn=0 in cycle T0+20 -> all outputs 0 immediately.
